phase_sequencer: RTL

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Generates the per-phase strobes for a multi-phase processor round. Each round
// is NUM_PHASES phases long and every phase lasts D clock cycles. D comes from
// div_ratio, which is captured only when phase 0 is entered. A value of 0 is
// treated as 1.
//
// At the end of every phase the sequencer samples stall_req. If the memory or
// register file is busy, the sequencer parks in STALL until the request drops.
// When enable falls, the current round still runs to completion. The sequencer
// then returns to IDLE.
//
// Optional feature (compile-time macro PHASE_SEQ_WATCHDOG_EN):
//   Adds a stall watchdog. When a stall lasts 2^DIV_W-1 consecutive cycles the
//   sequencer is forced back to RUN, and the sticky stall_timeout flag is set.
//   Only reset clears stall_timeout.
//
// Parameters
//   NUM_PHASES : phases per round (2..8)
//   DIV_W      : width of div_ratio and of the watchdog counter
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   enable        in   1 = keep running rounds, 0 = stop after current round
//   div_ratio     in   cycles per phase (0 behaves as 1)
//   stall_req     in   hold request, sampled on the last cycle of each phase
//   phase_en      out  one-hot strobe on the first cycle of each phase
//   phase_idx     out  current phase index
//   round_done    out  pulse on the last cycle of the final phase
//   stall_ack     out  high while held in STALL
//   running       out  high in RUN or STALL
//   stall_timeout out  (watchdog build only) sticky watchdog expiry flag
//
// State table
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no round in progress; waiting for enable
//   S_RUN   | counting cycles within the current phase
//   S_STALL | phase finished, next phase held off by stall_req
// -----------------------------------------------------------------------------
module phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int DIV_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      div_ratio,
    input  logic                  stall_req,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic [2:0]            phase_idx,
    output logic                  round_done,
    output logic                  stall_ack,
    output logic                  running
`ifdef PHASE_SEQ_WATCHDOG_EN
    ,
    output logic                  stall_timeout
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

    state_t           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q,   div_d;

    logic [DIV_W-1:0] div_eff;
    logic             last_cycle;
    logic             advance;
    logic             wd_expire;

    // A ratio of 0 would give a phase with no cycles, so it is promoted to 1.
    assign div_eff    = (div_ratio == '0) ? DIV_W'(1) : div_ratio;
    // div_q is never 0 once latched, so this subtraction cannot wrap.
    assign last_cycle = (count_q == (div_q - DIV_W'(1)));

`ifdef PHASE_SEQ_WATCHDOG_EN
    // The counter holds the number of completed stall cycles minus one. It
    // reaches 2^DIV_W-2 on the (2^DIV_W-1)-th consecutive stall cycle.
    localparam logic [DIV_W-1:0] WD_LAST = {DIV_W{1'b1}} - DIV_W'(1);

    logic [DIV_W-1:0] wd_q, wd_d;
    logic             timeout_q, timeout_d;

    assign wd_expire = (state_q == S_STALL) && (wd_q == WD_LAST);

    always_comb begin
        wd_d      = '0;
        timeout_d = timeout_q;
        if (state_q == S_STALL && stall_req) begin
            if (wd_expire) begin
                timeout_d = 1'b1;
            end else begin
                wd_d = wd_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        div_d   = div_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_RUN;
                    phase_d = '0;
                    count_d = '0;
                    div_d   = div_eff;
                end
            end
            S_RUN: begin
                if (!last_cycle) begin
                    count_d = count_q + DIV_W'(1);
                end else if (stall_req) begin
                    // Hold the phase index. The phase advances on exit from STALL.
                    state_d = S_STALL;
                    count_d = '0;
                end else begin
                    advance = 1'b1;
                end
            end
            S_STALL: begin
                if (!stall_req || wd_expire) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
                count_d = '0;
            end
        endcase

        // The phase step is shared by the RUN and STALL exits. This lets the
        // enable check at a round boundary also apply after a stall that began
        // on the round_done cycle.
        if (advance) begin
            count_d = '0;
            if (phase_q == LAST_PHASE) begin
                phase_d = '0;
                if (enable) begin
                    state_d = S_RUN;
                    div_d   = div_eff;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                phase_d = phase_q + 3'd1;
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            count_q <= '0;
            div_q   <= DIV_W'(1);
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            div_q   <= div_d;
        end
    end

    // The outputs decode from registered state only. Reset therefore clears
    // them as soon as reset is asserted, without waiting for a clock edge.
    assign phase_en   = (state_q == S_RUN && count_q == '0)
                        ? (NUM_PHASES'(1) << phase_q) : '0;
    assign phase_idx  = phase_q;
    assign round_done = (state_q == S_RUN) && last_cycle && (phase_q == LAST_PHASE);
    assign stall_ack  = (state_q == S_STALL);
    assign running    = (state_q != S_IDLE);

endmodule
